// File: rtl/shadow_rom_pkg.sv
// shadow_rom_pkg: shared state encoding, checksum width and width helper for the shadow ROM loader.
package shadow_rom_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int SUM_W = 16;

  // smallest width able to index 'value' distinct codes (0 for value <= 1)
  function automatic int clog2_f(input int value);
    int      width;
    longint  span;
    width = 0;
    span  = 64'sd1;
    while (span < longint'(value)) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/shadow_rom_ram.sv
// shadow_rom_ram: simple dual-port block RAM with a synchronous write port and a registered read port.
module shadow_rom_ram #(
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 8,
  parameter int AW     = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port, no reset so the output register maps into the RAM primitive
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/shadow_rom_loader.sv
// shadow_rom_loader: clears a RAM, streams a boot image into it, then serves registered CPU reads.
// Defining SHADOW_ROM_CHECKSUM_EN adds EXPECT_SUM / sum and gates DONE on a 16-bit image checksum.
module shadow_rom_loader
  import shadow_rom_pkg::*;
#(
  parameter int                ADDR_W      = 14,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16384,
  parameter int                LOAD_BASE   = 0,
  parameter int                LOAD_LEN    = 9216,
  parameter logic [DATA_W-1:0] FILL        = {DATA_W{1'b0}},
  parameter int                TIMEOUT_CYC = 65535
`ifdef SHADOW_ROM_CHECKSUM_EN
  ,
  parameter logic [SUM_W-1:0]  EXPECT_SUM  = 16'h0000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SHADOW_ROM_CHECKSUM_EN
  ,
  output logic [SUM_W-1:0]  sum
`endif
);

  localparam int AW = (clog2_f(DEPTH) < 1) ? 1 : clog2_f(DEPTH);
  localparam int PW = (clog2_f(DEPTH + 1) < 1) ? 1 : clog2_f(DEPTH + 1);
  localparam int IW = (clog2_f(TIMEOUT_CYC + 1) < 1) ? 1 : clog2_f(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] LAST_CLR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] BASE_P   = PW'(LOAD_BASE);
  localparam logic [PW-1:0] LAST_CNT = PW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] TMO      = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_MAX = {IW{1'b1}};

  if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_depth_chk
    $fatal(1, "shadow_rom_loader: DEPTH exceeds 2**ADDR_W");
  end
  if ((LOAD_LEN < 1) || (LOAD_BASE + LOAD_LEN > DEPTH)) begin : g_load_chk
    $fatal(1, "shadow_rom_loader: load window does not fit in DEPTH");
  end

  state_t            state_r;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     cnt_r;
  logic [IW-1:0]     idle_r;
  logic              ld_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              rd_ok_r;

  logic              accept_s;
  logic              launch_s;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic [IW-1:0]     idle_inc_s;
  logic              a_ok_s;
  logic              sum_ok_s;
  logic [DATA_W-1:0] ram_q_s;

  assign accept_s = ld_valid & ld_ready_r;
  assign launch_s = start & ~busy_r;
  assign a_ok_s   = (64'(a) < 64'(DEPTH));

  // RAM write source: fill pattern while clearing, stream word while loading
  always_comb begin
    if (state_r == CLEAR) begin
      we_s    = 1'b1;
      wdata_s = FILL;
    end else begin
      we_s    = accept_s;
      wdata_s = ld_data;
    end
  end

  // saturating idle-cycle increment
  always_comb begin
    if (idle_r == IDLE_MAX) begin
      idle_inc_s = idle_r;
    end else begin
      idle_inc_s = idle_r + IW'(1'b1);
    end
  end

`ifdef SHADOW_ROM_CHECKSUM_EN
  logic [SUM_W-1:0] sum_r;
  logic [SUM_W-1:0] sum_nxt_s;

  assign sum_nxt_s = sum_r + SUM_W'(ld_data);
  assign sum_ok_s  = (sum_nxt_s == EXPECT_SUM);
  assign sum       = sum_r;

  // running image checksum: cleared when a load is launched, holds after the load ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (launch_s) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (accept_s) begin
      sum_r <= sum_nxt_s;
    end
  end
`else
  assign sum_ok_s = 1'b1;
`endif

  // load sequencer: clear, stream, then park in DONE or ERR until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {PW{1'b0}};
      cnt_r      <= {PW{1'b0}};
      idle_r     <= {IW{1'b0}};
      ld_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (launch_s) begin
            state_r <= CLEAR;
            ptr_r   <= {PW{1'b0}};
            cnt_r   <= {PW{1'b0}};
            idle_r  <= {IW{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        CLEAR: begin
          if (ptr_r == LAST_CLR) begin
            state_r    <= LOAD;
            ptr_r      <= BASE_P;
            cnt_r      <= {PW{1'b0}};
            idle_r     <= {IW{1'b0}};
            ld_ready_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + PW'(1'b1);
          end
        end
        LOAD: begin
          if (accept_s) begin
            ptr_r  <= ptr_r + PW'(1'b1);
            cnt_r  <= cnt_r + PW'(1'b1);
            idle_r <= {IW{1'b0}};
            if (cnt_r == LAST_CNT) begin
              ld_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              if (sum_ok_s) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ERR;
                err_r   <= 1'b1;
              end
            end
          end else begin
            idle_r <= idle_inc_s;
            if (idle_inc_s >= TMO) begin
              state_r    <= ERR;
              err_r      <= 1'b1;
              ld_ready_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          ld_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // read qualifier: only a completed image inside the array is visible to the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ok_r <= 1'b0;
    end else begin
      rd_ok_r <= (state_r == DONE) && a_ok_s;
    end
  end

  shadow_rom_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (ptr_r[AW-1:0]),
    .wdata (wdata_s),
    .raddr (a[AW-1:0]),
    .rdata (ram_q_s)
  );

  assign dout     = rd_ok_r ? ram_q_s : FILL;
  assign ld_ready = ld_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: doc/shadow_rom_loader.md
Name: shadow_rom_loader

Overview:
- Parametrised boot/firmware ROM that is loaded at run time instead of by elaboration-time file initialisation.
- After a start pulse:
  - clears a BRAM array to a fill value;
  - accepts an image byte stream from the flash reader over a valid/ready handshake;
  - then serves registered reads to the CPU.
- Sits between the SPI flash reader and the CPU memory decoder; replaces fixed bootloader/divMMC image memories.

Parameters:
- ADDR_W, 14, CPU address width.
- DATA_W, 8, data width.
- DEPTH, 16384, number of words; must satisfy DEPTH ≤ 2**ADDR_W.
- LOAD_BASE, 0, first word address written by the stream.
- LOAD_LEN, 9216, words accepted per load; LOAD_BASE+LOAD_LEN ≤ DEPTH (elaboration-time check, fatal).
- FILL, 0, value written during clear and returned while not loaded.
- TIMEOUT_CYC, 65535, maximum idle cycles between stream words before abort.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse that begins clear+load.
- ld_data, in, DATA_W, stream word.
- ld_valid, in, 1, stream word present.
- ld_ready, out, 1, block accepts a word this cycle.
- a, in, ADDR_W, CPU read address.
- dout, out, DATA_W, read data, registered.
- busy, out, 1, clear or load in progress.
- done, out, 1, image loaded successfully (sticky until next start/reset).
- err, out, 1, load aborted (sticky until next start/reset).

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - dout = FILL, ld_ready = 0, busy = 0, done = 0, err = 0.
  - Counters are 0.
  - BRAM contents are not reset.
- FSM states:
  - IDLE: waits for start, then goes to CLEAR; clears done and err, clears the pointer.
  - CLEAR: writes FILL to address ptr, one word per cycle. After ptr reaches DEPTH-1 it goes to LOAD, with ptr = LOAD_BASE and the word counter at 0.
  - LOAD: ld_ready = 1. On ld_valid&&ld_ready it writes ld_data at ptr, increments ptr, increments the count, and resets the idle counter. When the accepted word is number LOAD_LEN it goes to DONE; ld_ready is 0 in the following cycle.
    - While ld_valid = 0 the idle counter increments. When it reaches TIMEOUT_CYC the FSM goes to ERR.
  - DONE: done = 1; start restarts at CLEAR.
  - ERR: err = 1; start restarts at CLEAR.
- busy = 1 exactly in CLEAR and LOAD. start is ignored while busy.
- Reads, one-cycle latency: dout <= mem[a] on every clk edge when in DONE and a < DEPTH. Otherwise dout <= FILL: while busy, in IDLE or ERR, or when a ≥ DEPTH.
- Write and read never collide on the CPU side, because reads are masked while busy.
- Counter widths:
  - ptr and count are clog2(DEPTH+1) bits.
  - Idle counter is clog2(TIMEOUT_CYC+1) bits and saturates.
  - No wrap-around is possible.
- Reset mid-operation: the FSM returns to IDLE immediately, ld_ready drops asynchronously, and the partially written memory is stale. done stays 0 until a fresh start completes.
- ld_valid asserted outside LOAD: ignored, nothing consumed.
- Last word accepted together with start in the same cycle: start is ignored, because the block is still busy.

Optional Feature:
- Macro: SHADOW_ROM_CHECKSUM_EN.
- Defined:
  - Adds parameter EXPECT_SUM (16 bits, default 0) and output port sum (16 bits).
  - sum is cleared on start and accumulates the zero-extended accepted words modulo 2^16.
  - On the final word the FSM compares the final sum (including that word) with EXPECT_SUM: equal goes to DONE, mismatch goes to ERR.
  - sum holds its value after the load ends.
- Undefined: no sum port, no EXPECT_SUM parameter; err is raised only by timeout.

Decomposition:
- Package shadow_rom_pkg:
  - state encoding (IDLE, CLEAR, LOAD, DONE, ERR);
  - width helper function (clog2);
  - checksum width constant (16).
- One sub-module: shadow_rom_ram.
  - Simple dual-port BRAM, DEPTH × DATA_W.
  - One synchronous write port and one registered read port, so the tools infer block RAM.
- FSM, counters, handshake and read masking stay in shadow_rom_loader.

Test Plan:
- Reset then read a=0x0000 → dout=0x00 next cycle; busy=0, done=0, ld_ready=0.
- start pulse, then 16384 CLEAR cycles (busy=1, ld_ready=0), then stream 9216 bytes i&0xFF with ld_valid held high. Required result:
  - done=1 the cycle after the last accept;
  - read a=0x0005 → 0x05;
  - a=0x23FF → 0xFF;
  - a=0x2400 → 0x00 (cleared region).
- Stream with ld_valid toggling 1/0 each cycle and TIMEOUT_CYC=4 → load completes with no err. Stall ld_valid for 5 cycles mid-load → err=1, done=0, reads return FILL.
- Assert rst at word 100 of a load → ld_ready=0 immediately, state IDLE, done=0. New start plus a full stream → done=1 with correct data.
- start pulsed during LOAD, and ld_valid asserted during CLEAR → both ignored; accepted word count is exactly LOAD_LEN.
- With SHADOW_ROM_CHECKSUM_EN, 4 words 0x01,0x02,0x03,0x04 (LOAD_LEN=4):
  - EXPECT_SUM=0x000A → done=1, sum=0x000A;
  - EXPECT_SUM=0x000B → err=1, done=0.
